// File: rtl/picorv32_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : picorv32_mem_responder_if
// Brief    : PicoRV32 native memory handshake bundle (core = master).
// Revision : 1.0
// ============================================================================
interface picorv32_mem_responder_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/picorv32_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : picorv32_mem_responder
// Brief    : SRAM + console + pass-flag target for the PicoRV32 memory bus.
// Revision : 1.0
// ============================================================================
module picorv32_mem_responder #(
    parameter int          MEM_WORDS    = 32768,
    parameter int          WAIT_CYCLES  = 0,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter logic [31:0] PASS_ADDR    = 32'h2000_0000,
    parameter logic [31:0] PASS_VALUE   = 32'd123456789
) (
    input  wire logic                     clock,
    input  wire logic                     resetn,
    picorv32_mem_responder_if.slave       bus,
    output logic                          tests_passed,
    output logic                          console_valid,
    output logic [7:0]                    console_data,
    output logic                          bus_error
);
    localparam int          c_AW        = $clog2(MEM_WORDS);
    localparam logic [7:0]  c_WAIT_LOAD = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2,
        S_TURN = 2'd3
    } state_t;

    logic [31:0] sram [MEM_WORDS];

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [29:0] r_waddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_ready;
    logic [31:0] r_rdata;

    logic        w_take;
    logic        w_enter_resp;
    logic [29:0] w_waddr;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic        w_wr;
    logic        w_is_sram;
    logic        w_is_con;
    logic        w_is_pass;
    logic [c_AW-1:0] w_word;
    logic [31:0] w_rdata;
    logic        w_unmapped;
    logic        w_unused_lsb;

    assign w_unused_lsb = ^bus.mem_addr[1:0];

    assign w_take       = (r_state == S_IDLE) && bus.mem_valid;
    assign w_enter_resp = (w_take && (WAIT_CYCLES == 0)) ||
                          ((r_state == S_WAIT) && (r_cnt == 8'd0));

    // With zero wait states the access happens on the capture edge itself,
    // so the decode must look at the live bus rather than the request regs.
    assign w_waddr = (r_state == S_IDLE) ? bus.mem_addr[31:2] : r_waddr;
    assign w_wdata = (r_state == S_IDLE) ? bus.mem_wdata      : r_wdata;
    assign w_wstrb = (r_state == S_IDLE) ? bus.mem_wstrb      : r_wstrb;

    assign w_wr      = |w_wstrb;
    assign w_is_sram = w_waddr < 30'(MEM_WORDS);
    assign w_is_con  = w_waddr == CONSOLE_ADDR[31:2];
    assign w_is_pass = w_waddr == PASS_ADDR[31:2];
    assign w_word    = w_waddr[c_AW-1:0];

    always_comb begin
        w_rdata    = 32'h0;
        w_unmapped = 1'b0;
        if (w_is_sram) begin
            if (!w_wr) w_rdata = sram[w_word];
        end else if (w_is_pass) begin
            if (!w_wr) w_rdata = {31'b0, tests_passed};
        end else if (!w_is_con) begin
            w_unmapped = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_cnt         <= 8'd0;
            r_waddr       <= 30'd0;
            r_wdata       <= 32'd0;
            r_wstrb       <= 4'd0;
            r_ready       <= 1'b0;
            r_rdata       <= 32'd0;
            console_valid <= 1'b0;
            console_data  <= 8'd0;
            tests_passed  <= 1'b0;
            bus_error     <= 1'b0;
        end else begin
            r_ready       <= 1'b0;
            console_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.mem_valid) begin
                        r_waddr <= bus.mem_addr[31:2];
                        r_wdata <= bus.mem_wdata;
                        r_wstrb <= bus.mem_wstrb;
                        r_cnt   <= c_WAIT_LOAD;
                        r_state <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 8'd0) r_state <= S_RESP;
                    else               r_cnt   <= r_cnt - 8'd1;
                end
                S_RESP:  r_state <= S_TURN;
                default: r_state <= S_IDLE;
            endcase

            if (w_enter_resp) begin
                r_ready <= 1'b1;
                r_rdata <= w_rdata;
                if (w_unmapped) bus_error <= 1'b1;
                if (!w_is_sram && w_is_con && w_wr) begin
                    console_valid <= 1'b1;
                    console_data  <= w_wdata[7:0];
                end
                if (!w_is_sram && w_is_pass && w_wr)
                    tests_passed <= (w_wdata == PASS_VALUE);
            end
        end
    end

    // Storage is deliberately outside the reset domain so a preload survives reset.
    always_ff @(posedge clock) begin
        if (w_enter_resp && w_is_sram && w_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wstrb[i]) sram[w_word][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    assign bus.mem_ready = r_ready;
    assign bus.mem_rdata = r_rdata;
endmodule
`default_nettype wire

// File: doc/picorv32_mem_responder.md
# picorv32_mem_responder

- Synthesizable responder for the PicoRV32 native memory interface; it serves the core's instruction and data requests.
- Provides word-addressed SRAM with byte-lane writes, a programmable number of wait states, a console byte port, and a sticky test-pass flag.
- Sits between the `Picorv32` core and the bench or top level, as the target side of the `mem_valid`/`mem_ready` handshake.

## Interface
Parameters:
- MEM_WORDS, 32768, SRAM depth in 32-bit words (128 KiB); storage array named `sram` so `$readmemh` can preload it hierarchically
- WAIT_CYCLES, 0, extra wait states inserted before each `mem_ready` (0..255)
- CONSOLE_ADDR, 32'h1000_0000, write-only console byte register
- PASS_ADDR, 32'h2000_0000, write-only test-result register
- PASS_VALUE, 32'd123456789, value that marks the tests as passed

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- resetn  in  1  asynchronous, active-low reset
- mem_valid  in  1  request from the core
- mem_ready  out  1  one-cycle response strobe
- mem_addr  in  32  byte address; bits [1:0] ignored
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte-lane write enables; 0 means read
- mem_rdata  out  32  read data; valid while `mem_ready`=1
- tests_passed  out  1  sticky pass flag
- console_valid  out  1  one-cycle strobe when a console byte is written
- console_data  out  8  console byte, held until the next console write
- bus_error  out  1  sticky flag, set by any access to an unmapped address

## Operation
- FSM states: IDLE, WAIT, RESP, TURN.
- **IDLE**
  - `mem_valid`=1 with WAIT_CYCLES=0 → RESP.
  - `mem_valid`=1 with WAIT_CYCLES>0 → WAIT, with an 8-bit counter loaded to WAIT_CYCLES-1.
  - Address, wdata and wstrb are captured into request registers at this edge.
- **WAIT**: the counter decrements each cycle; when it reaches 0, go to RESP.
- **RESP**: the access is performed on the transition into RESP; `mem_ready`=1 for exactly this cycle; next state TURN.
- **TURN**: one dead cycle in which `mem_valid` is ignored; next state IDLE. This guarantees the core has dropped `mem_valid` before the next sample.
- Address decode (on the captured address, word = addr[31:2]):
  - addr < 4*MEM_WORDS: SRAM.
    - Read (wstrb=0): `mem_rdata` = sram[word].
    - Write: bytes with wstrb[i]=1 update sram[word][8i+7:8i]; other bytes are untouched; `mem_rdata` = 0.
  - addr == CONSOLE_ADDR with wstrb≠0:
    - `console_data` = wdata[7:0] and `console_valid`=1, both coincident with `mem_ready`.
    - A read of CONSOLE_ADDR returns 0 and raises no error.
  - addr == PASS_ADDR with wstrb≠0:
    - wdata == PASS_VALUE sets `tests_passed`.
    - Any other value clears it.
    - A read returns {31'b0, tests_passed}.
  - Any other address: the access still completes (no hang); `mem_rdata` = 32'h0; `bus_error` set; no state change.
- `mem_rdata` holds its last value outside RESP; consumers use it only while `mem_ready`=1.
- SRAM contents are not reset; the preload survives reset.

## Timing
- Reset (resetn=0, asynchronous, immediate):
  - state = IDLE
  - `mem_ready`=0, `mem_rdata`=0
  - `console_valid`=0, `console_data`=0
  - `tests_passed`=0, `bus_error`=0
  - wait counter = 0
- Latency: `mem_valid` sampled high at edge N → `mem_ready` high during cycle N+1+WAIT_CYCLES.
- Throughput: one transfer per 3+WAIT_CYCLES cycles.
- `mem_ready` is never high on two consecutive cycles.
- `console_valid` is high only coincident with `mem_ready`.
- Inputs are sampled only at the IDLE→WAIT/RESP edge. Changes on mem_addr/mem_wdata/mem_wstrb during WAIT, RESP or TURN have no effect.
- Reset asserted during WAIT or RESP:
  - The pending access is abandoned.
  - An SRAM write that has not yet reached RESP is not performed.
  - The FSM restarts in IDLE after resetn releases.
- `mem_valid` dropping during WAIT (protocol violation): the response still completes in order, and the FSM returns to IDLE normally.
- Counter wrap: WAIT_CYCLES=255 loads 254 and never underflows.

## Test plan
- WAIT_CYCLES=0; read word 0 preloaded with 32'h0000_0093:
  - valid at edge N → `mem_ready` high in cycle N+1 with rdata=32'h0000_0093, low in N+2 (TURN).
- WAIT_CYCLES=3; write addr 0x104, wdata=32'hAABB_CCDD, wstrb=4'b0101, over prior 32'h1122_3344:
  - ready at N+4.
  - A following read returns 32'h11BB_33DD.
- Write 0x41 to CONSOLE_ADDR → `console_valid` one-cycle pulse with `console_data`=8'h41, coincident with `mem_ready`.
- Write 123456789 to PASS_ADDR → `tests_passed`=1 and stays 1 through later accesses.
  - A subsequent write of 0 clears it.
  - Reset clears it.
- Read 0x3000_0000:
  - `mem_ready` still asserted with rdata=0 and `bus_error`=1 (sticky).
  - A subsequent valid SRAM read succeeds and `bus_error` stays 1.
- WAIT_CYCLES=5; assert resetn=0 two cycles after a write request is accepted:
  - `mem_ready` drops immediately and no SRAM byte changes.
  - After release, a new read completes at N+6.
